// File: rtl/cordic_pass_ctrl.sv
// Sequences one neuron evaluation through the shared CORDIC datapath:
// a linear MAC pass, then an optional hyperbolic activation pass seeded from the seed latch.
module cordic_pass_ctrl #(
    parameter int unsigned WIDTH     = 15,
    parameter int unsigned ITER_LAST = 10,
    parameter int unsigned REPEAT_IT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             af_req,
    input  logic [WIDTH:0]   x_in,
    input  logic [WIDTH:0]   y_in,
    input  logic [WIDTH:0]   z_in,
    input  logic [WIDTH:0]   Xout,
    input  logic [WIDTH:0]   Yout,
    input  logic [WIDTH:0]   Zout,
    input  logic [WIDTH:0]   X_H,
    input  logic [WIDTH:0]   Y_H,
    input  logic [WIDTH:0]   Z_H,
    output logic [WIDTH:0]   X0,
    output logic [WIDTH:0]   Y0,
    output logic [WIDTH:0]   Z0,
    output logic             load,
    output logic             mode,
    output logic [3:0]       i,
    output logic             af_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   res_x,
    output logic [WIDTH:0]   res_y
);

    localparam logic [3:0] I_LAST = 4'(ITER_LAST);
    localparam logic [3:0] I_REP  = 4'(REPEAT_IT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD1,
        S_RUN1,
        S_HANDOFF,
        S_LOAD2,
        S_RUN2,
        S_DONE
    } state_t;

    state_t         state_q, state_nx;
    logic           af_req_q, af_req_nx;
    logic           rep_q, rep_nx;
    logic [WIDTH:0] x0_nx, y0_nx, z0_nx, res_x_nx, res_y_nx;
    logic [3:0]     i_nx;
    logic           load_nx, mode_nx, af_en_nx, busy_nx, done_nx;

    // Zout is not needed for results; only X/Y leave this block.
    logic           unused_zout;
    assign unused_zout = ^Zout;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            af_req_q <= 1'b0;
            rep_q    <= 1'b0;
            X0       <= '0;
            Y0       <= '0;
            Z0       <= '0;
            load     <= 1'b0;
            mode     <= 1'b0;
            i        <= '0;
            af_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_x    <= '0;
            res_y    <= '0;
        end else begin
            state_q  <= state_nx;
            af_req_q <= af_req_nx;
            rep_q    <= rep_nx;
            X0       <= x0_nx;
            Y0       <= y0_nx;
            Z0       <= z0_nx;
            load     <= load_nx;
            mode     <= mode_nx;
            i        <= i_nx;
            af_en    <= af_en_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            res_x    <= res_x_nx;
            res_y    <= res_y_nx;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nx  = state_q;
        af_req_nx = af_req_q;
        rep_nx    = rep_q;
        x0_nx     = X0;
        y0_nx     = Y0;
        z0_nx     = Z0;
        i_nx      = i;
        res_x_nx  = res_x;
        res_y_nx  = res_y;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_LOAD1;
                    x0_nx     = x_in;
                    y0_nx     = y_in;
                    z0_nx     = z_in;
                    af_req_nx = af_req;
                    i_nx      = '0;
                end
            end
            S_LOAD1: state_nx = S_RUN1;
            S_RUN1: begin
                if (i == I_LAST) begin
                    if (af_req_q) begin
                        state_nx = S_HANDOFF;
                    end else begin
                        state_nx = S_DONE;
                        res_x_nx = Xout;
                        res_y_nx = Yout;
                    end
                end else begin
                    i_nx = i + 4'd1;
                end
            end
            S_HANDOFF: begin
                state_nx = S_LOAD2;
                x0_nx    = X_H;
                y0_nx    = Y_H;
                z0_nx    = Z_H;
                i_nx     = 4'd1;
                rep_nx   = 1'b0;
            end
            S_LOAD2: state_nx = S_RUN2;
            S_RUN2: begin
                // Hyperbolic convergence needs the repeat index executed twice
                if (i == I_REP && !rep_q) begin
                    rep_nx = 1'b1;
                end else if (i == I_LAST) begin
                    state_nx = S_DONE;
                    res_x_nx = Xout;
                    res_y_nx = Yout;
                end else begin
                    i_nx = i + 4'd1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        load_nx  = (state_nx == S_LOAD1) || (state_nx == S_LOAD2);
        mode_nx  = (state_nx == S_LOAD2) || (state_nx == S_RUN2);
        af_en_nx = (state_nx == S_RUN1) && (i_nx == I_LAST) && af_req_q;
        busy_nx  = (state_nx != S_IDLE);
        done_nx  = (state_nx == S_DONE);
    end

endmodule

// File: tb/tb_cordic_pass_ctrl.sv
// Directed bench for cordic_pass_ctrl with a behavioural datapath and seed latch.
module tb_cordic_pass_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        af_req = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic [15:0] Xout, Yout, Zout;
    logic [15:0] X_H = '0, Y_H = '0, Z_H = '0;
    logic [15:0] X0, Y0, Z0, res_x, res_y;
    logic        load, mode, af_en, busy, done;
    logic [3:0]  i;

    int checks = 0;
    int errors = 0;

    logic [15:0] y_tgt = '0;

    int          done_cyc, done_cnt, af_cnt, af_at_i, mode_cnt, rst_done;
    logic [15:0] ld1_x0, ld2_x0, ld2_y0, ld2_z0;
    logic        ld2_mode;
    int          i_log[$];
    int          exp_seq[11] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10};

    cordic_pass_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .af_req(af_req),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .Xout(Xout), .Yout(Yout), .Zout(Zout),
        .X_H(X_H), .Y_H(Y_H), .Z_H(Z_H),
        .X0(X0), .Y0(Y0), .Z0(Z0),
        .load(load), .mode(mode), .i(i), .af_en(af_en),
        .busy(busy), .done(done), .res_x(res_x), .res_y(res_y)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: final-stage values depend on pass, filler elsewhere
    always_comb begin
        Xout = (i == 4'd10) ? (mode ? 16'h0444 : 16'h0111) : 16'h6666;
        Yout = (i == 4'd10) ? (mode ? 16'h0333 : y_tgt)    : 16'h7777;
        Zout = 16'h5555;
    end

    // Seed latch: x = 1/Kh, y = 0, z = MAC result
    always @(posedge clk) begin
        if (af_en) begin
            X_H <= 16'h04D4;
            Y_H <= 16'h0000;
            Z_H <= Yout;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_X0"}, 32'(X0), 32'h0);
        check({p, "_Y0"}, 32'(Y0), 32'h0);
        check({p, "_Z0"}, 32'(Z0), 32'h0);
        check({p, "_load"}, 32'(load), 32'h0);
        check({p, "_mode"}, 32'(mode), 32'h0);
        check({p, "_i"}, 32'(i), 32'h0);
        check({p, "_af_en"}, 32'(af_en), 32'h0);
        check({p, "_busy"}, 32'(busy), 32'h0);
        check({p, "_done"}, 32'(done), 32'h0);
        check({p, "_res_x"}, 32'(res_x), 32'h0);
        check({p, "_res_y"}, 32'(res_y), 32'h0);
    endtask

    // One accepted start, observed for 40 cycles; extra start pulses at cycles poke_a/poke_b
    task automatic run_op(input logic af, input int poke_a, input int poke_b);
        done_cyc = 0; done_cnt = 0; af_cnt = 0; af_at_i = -1; mode_cnt = 0;
        ld1_x0 = '0; ld2_x0 = '1; ld2_y0 = '1; ld2_z0 = '1; ld2_mode = 1'b0;
        i_log.delete();
        @(negedge clk);
        af_req = af;
        start  = 1'b1;
        @(posedge clk);
        #1;
        af_req = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (n == 1) ld1_x0 = X0;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n + 1;
            end
            if (af_en) begin
                af_cnt++;
                af_at_i = int'(i);
            end
            if (mode) mode_cnt++;
            if (load && mode) begin
                ld2_x0 = X0; ld2_y0 = Y0; ld2_z0 = Z0; ld2_mode = mode;
            end
            if (mode && !load) i_log.push_back(int'(i));
            if (n == poke_a || n == poke_b) begin
                start = 1'b1;
                x_in  = 16'hDEAD;
            end
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_zero("idle");

        // Pass 1 only
        x_in = 16'h0100; y_in = 16'h0000; z_in = 16'h0080; y_tgt = 16'h0080;
        run_op(1'b0, 0, 0);
        check("a_ld1_x0", 32'(ld1_x0), 32'h0100);
        check("a_done_cycle", 32'(done_cyc), 32'd14);
        check("a_done_count", 32'(done_cnt), 32'd1);
        check("a_res_y", 32'(res_y), 32'h0080);
        check("a_res_x", 32'(res_x), 32'h0111);
        check("a_af_en_count", 32'(af_cnt), 32'd0);
        check("a_mode_count", 32'(mode_cnt), 32'd0);
        check("a_busy_end", 32'(busy), 32'd0);

        // Pass 1 + activation
        x_in = 16'h0100; y_tgt = 16'h0200;
        run_op(1'b1, 0, 0);
        check("b_af_en_count", 32'(af_cnt), 32'd1);
        check("b_af_en_at_i", 32'(af_at_i), 32'd10);
        check("b_ld2_x0", 32'(ld2_x0), 32'h04D4);
        check("b_ld2_y0", 32'(ld2_y0), 32'h0000);
        check("b_ld2_z0", 32'(ld2_z0), 32'h0200);
        check("b_ld2_mode", 32'(ld2_mode), 32'd1);
        check("b_done_cycle", 32'(done_cyc), 32'd27);
        check("b_done_count", 32'(done_cnt), 32'd1);
        check("b_res_x", 32'(res_x), 32'h0444);
        check("b_res_y", 32'(res_y), 32'h0333);
        check("b_run2_len", 32'(i_log.size()), 32'd11);
        for (int k = 0; k < 11; k++) begin
            if (k < i_log.size()) check($sformatf("b_run2_i%0d", k), 32'(i_log[k]), 32'(exp_seq[k]));
            else check($sformatf("b_run2_i%0d", k), 32'hFFFF_FFFF, 32'(exp_seq[k]));
        end

        // Start pulses during RUN1 and in the DONE cycle are ignored
        x_in = 16'h0100; y_tgt = 16'h00A5;
        run_op(1'b0, 5, 13);
        check("c_done_count", 32'(done_cnt), 32'd1);
        check("c_done_cycle", 32'(done_cyc), 32'd14);
        check("c_res_y", 32'(res_y), 32'h00A5);
        check("c_ld1_x0", 32'(ld1_x0), 32'h0100);
        check("c_x0_held", 32'(X0), 32'h0100);
        check("c_busy_end", 32'(busy), 32'd0);

        // Reset at RUN2 i=6
        x_in = 16'h0100; y_tgt = 16'h0200;
        @(negedge clk);
        af_req = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        af_req = 1'b0;
        for (int n = 0; n < 40 && !(mode && !load && i == 4'd6); n++) begin
            @(posedge clk);
            #1;
        end
        check("d_reached_run2_i6", 32'(mode && !load && i == 4'd6), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("d_after_reset");
        rst_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) rst_done++;
        end
        check("d_no_done_after_abort", 32'(rst_done), 32'd0);

        // Normal operation after abort
        x_in = 16'h0123; y_tgt = 16'h0042;
        run_op(1'b0, 0, 0);
        check("e_ld1_x0", 32'(ld1_x0), 32'h0123);
        check("e_done_cycle", 32'(done_cyc), 32'd14);
        check("e_done_count", 32'(done_cnt), 32'd1);
        check("e_res_y", 32'(res_y), 32'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
